integrator_mc: RTL and testbench
================================

// Module: integrator_mc
// PURPOSE
//   Multi-channel, time-multiplexed successor to the single-channel integrator core.
//   Holds N_CH independent accumulators and processes one sample per cycle with a
//   valid/ready stream on input and output.
//   Supports pure accumulate, leaky and integrate-and-dump modes, with per-channel
//   sticky overflow status.
//   Sits between the sample front-end (ADC/decimator) and the downstream filter/readout.
// PARAMETERS
//   N_CH      4   number of channels (>=2); CH_W = $clog2(N_CH)
//   IN_W      8   signed input sample width
//   ACC_W    16   signed accumulator width (ACC_W > IN_W)
//   CNT_W     8   dump-length counter width
// PORTS
//   clk          in   1       single clock, rising edge
//   rst          in   1       reset, asynchronous, active-high
//   enable       in   1       global enable; 0 forces in_ready=0, state held
//   in_valid     in   1       input sample valid
//   in_ready     out  1       input accepted when in_valid & in_ready
//   in_ch        in   CH_W    channel index of input sample (values >= N_CH are dropped)
//   in_data      in   IN_W    signed sample
//   mode         in   2       0=accumulate, 1=leaky, 2=integrate-and-dump, 3=reserved (acts as 0)
//   decay_shift  in   4       leaky k: y <- y - (y>>>k) + x
//   dump_len     in   CNT_W   samples per dump window (0 treated as 1)
//   sat_enable   in   1       1=clamp to [sat_neg, sat_pos], 0=two's-complement wrap
//   sat_pos      in   ACC_W   signed positive limit (sat_pos >= sat_neg required)
//   sat_neg      in   ACC_W   signed negative limit
//   clear        in   1       one-cycle pulse: zero channel clear_ch (acc, dump count, sticky)
//   clear_ch     in   CH_W    channel to clear
//   out_valid    out  1       result valid
//   out_ready    in   1       downstream accepts when out_valid & out_ready
//   out_ch       out  CH_W    channel of result
//   out_data     out  ACC_W   signed result
//   out_ovf      out  1       overflow/saturation occurred on this update
//   ovf_sticky   out  N_CH    per-channel sticky overflow; cleared by clear or reset
// BEHAVIOUR
//   Reset: all accumulators, dump counters, ovf_sticky = 0; out_valid=0;
//     out_ch/out_data/out_ovf=0. Reset mid-transfer discards any pending output.
//   Handshake:
//     - in_ready = enable & (!out_valid | out_ready); single output register, no skid.
//     - in_ready never depends on in_valid.
//     - out_valid, once high, holds with stable out_* until out_ready.
//   Accept (cycle N): the channel state updates at edge N; result is presented at
//     edge N (out_valid high in cycle N+1), i.e. 1-cycle latency.
//     Back-to-back samples on the same channel see the updated value (no hazard).
//   Arithmetic, in ACC_W+1 bits:
//     x = sext(in_data); base = acc (mode 0/2) or acc - (acc>>>k) (mode 1).
//     - k=0 in leaky mode gives base=0.
//     - k >= ACC_W gives base=acc (no decay).
//     - s = base + x.
//   Overflow: s outside the ACC_W signed range.
//     - sat_enable=1: result = clamp(s, sat_neg, sat_pos); out_ovf=1 if s was clamped
//       (range overflow or limit hit).
//     - sat_enable=0: result = s[ACC_W-1:0] (wrap); out_ovf = range overflow.
//     - out_ovf=1 sets ovf_sticky[ch].
//   Modes 0/1: every accepted sample stores the result and emits it on the output.
//   Mode 2 (integrate-and-dump): per-channel counter cnt counts accepted samples.
//     - cnt+1 < dump_len: store result, cnt++, no output; in_ready is still asserted.
//     - cnt+1 >= dump_len: emit result, reset acc and cnt to 0.
//     - out_ovf on a dump = OR of ovf over the window (per-channel window flag).
//     - Leaving mode 2 (mode!=2 at an accept) zeroes that channel's cnt.
//   Mode is sampled per accepted sample; changing mode never alters stored acc.
//   Clear:
//     - Takes effect at the edge it is high; independent of enable and handshake.
//     - Same edge as an accept on the same channel: clear first, then the sample adds
//       onto 0 (result = clamp/wrap of x).
//     - A clear never cancels a pending out_valid.
//   in_ch >= N_CH: the sample is accepted and dropped; no state change, no output.
//   enable=0: no accepts; a pending output still drains via out_ready.
// TESTING
//   1. Mode 0, ch0 samples 10,20,-5 back-to-back, out_ready=1 -> out_data 10,30,25 on
//      ch0, one result per cycle, latency 1.
//   2. Mode 1, k=2, acc=100, x=0 -> 75. Then k=0, x=7 -> 7.
//   3. sat_enable=1, sat_pos=1000, acc=990, x=+20 -> out_data=1000, out_ovf=1,
//      ovf_sticky[0]=1. sat_enable=0, acc=32767, x=1 -> -32768, out_ovf=1.
//   4. Mode 2, dump_len=4, ch1 samples 1,2,3,4 -> no output for the first 3, then
//      out_data=10 on ch1; the next sample starts from 0.
//   5. Interleave ch0/ch2 with out_ready low for 3 cycles -> in_ready=0, out_* stable;
//      no sample lost or duplicated; per-channel sums correct.
//   6. clear ch2 coincident with an accept ch2 x=5 (acc=50) -> out_data=5, sticky[2]=0.
//      rst asserted mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/integrator_mc.sv
// N_CH time-multiplexed accumulators (accumulate / leaky / integrate-and-dump), one sample per cycle.
// Result registered one cycle after accept; in_ready drops while an unread result is held (no skid).
module integrator_mc #(
  parameter int N_CH  = 4,
  parameter int IN_W  = 8,
  parameter int ACC_W = 16,
  parameter int CNT_W = 8,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [IN_W-1:0]   in_data,
  input  logic [1:0]        mode,
  input  logic [3:0]        decay_shift,
  input  logic [CNT_W-1:0]  dump_len,
  input  logic              sat_enable,
  input  logic [ACC_W-1:0]  sat_pos,
  input  logic [ACC_W-1:0]  sat_neg,
  input  logic              clear,
  input  logic [CH_W-1:0]   clear_ch,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH_W-1:0]   out_ch,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_ovf,
  output logic [N_CH-1:0]   ovf_sticky
);

  localparam int SW = ACC_W + 1;

  logic [ACC_W-1:0] acc_q [N_CH];
  logic [ACC_W-1:0] acc_d [N_CH];
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];
  logic [N_CH-1:0]  win_q, win_d, sticky_q, sticky_d;
  logic             out_valid_q, out_valid_d;
  logic [CH_W-1:0]  out_ch_q, out_ch_d;
  logic [ACC_W-1:0] out_data_q, out_data_d;
  logic             out_ovf_q, out_ovf_d;

  logic              accept, upd, ch_ok, clr_hit, mode2, dump, emit, ovf, emit_ovf;
  logic [ACC_W-1:0]  acc_cur, res, new_acc;
  logic [CNT_W-1:0]  cnt_cur, new_cnt;
  logic              win_cur, new_win;
  logic signed [SW-1:0] acc_ext, x_ext, base, s, pos_ext, neg_ext;
  logic [CNT_W:0]    cnt_inc, dlen;

  assign in_ready = enable & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;

  // Datapath for the addressed channel; a coincident clear on it is applied first.
  always_comb begin
    acc_cur = '0;
    cnt_cur = '0;
    win_cur = 1'b0;
    ch_ok   = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (in_ch == CH_W'(i)) begin
        acc_cur = acc_q[i];
        cnt_cur = cnt_q[i];
        win_cur = win_q[i];
        ch_ok   = 1'b1;
      end
    end
    clr_hit = clear && (clear_ch == in_ch);
    if (clr_hit) begin
      acc_cur = '0;
      cnt_cur = '0;
      win_cur = 1'b0;
    end
    upd = accept & ch_ok;

    acc_ext = {acc_cur[ACC_W-1], acc_cur};
    x_ext   = {{(SW-IN_W){in_data[IN_W-1]}}, in_data};
    base    = acc_ext;
    if (mode == 2'd1) begin
      if (decay_shift == 4'd0)
        base = '0;
      else if (32'(decay_shift) >= ACC_W)
        base = acc_ext;
      else
        base = acc_ext - (acc_ext >>> decay_shift);
    end
    s = base + x_ext;

    pos_ext = {sat_pos[ACC_W-1], sat_pos};
    neg_ext = {sat_neg[ACC_W-1], sat_neg};
    res = s[ACC_W-1:0];
    ovf = 1'b0;
    if (sat_enable) begin
      if (s > pos_ext) begin
        res = sat_pos;
        ovf = 1'b1;
      end else if (s < neg_ext) begin
        res = sat_neg;
        ovf = 1'b1;
      end
    end else begin
      ovf = s[SW-1] ^ s[SW-2];
    end

    mode2    = (mode == 2'd2);
    dlen     = (dump_len == '0) ? (CNT_W+1)'(1) : {1'b0, dump_len};
    cnt_inc  = {1'b0, cnt_cur} + (CNT_W+1)'(1);
    dump     = (cnt_inc >= dlen);
    emit     = ~mode2 | dump;
    new_acc  = (mode2 && dump) ? '0 : res;
    new_cnt  = (mode2 && !dump) ? cnt_inc[CNT_W-1:0] : '0;
    new_win  = mode2 && !dump && (win_cur | ovf);
    emit_ovf = mode2 ? (win_cur | ovf) : ovf;
  end

  always_comb begin
    win_d    = win_q;
    sticky_d = sticky_q;
    for (int i = 0; i < N_CH; i++) begin
      acc_d[i] = acc_q[i];
      cnt_d[i] = cnt_q[i];
      if (clear && (clear_ch == CH_W'(i))) begin
        acc_d[i]    = '0;
        cnt_d[i]    = '0;
        win_d[i]    = 1'b0;
        sticky_d[i] = 1'b0;
      end
      if (upd && (in_ch == CH_W'(i))) begin
        acc_d[i] = new_acc;
        cnt_d[i] = new_cnt;
        win_d[i] = new_win;
        if (ovf) sticky_d[i] = 1'b1;
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_ch_d    = out_ch_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    if (upd && emit) begin
      out_valid_d = 1'b1;
      out_ch_d    = in_ch;
      out_data_d  = res;
      out_ovf_d   = emit_ovf;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        acc_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      win_q       <= '0;
      sticky_q    <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        acc_q[i] <= acc_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      win_q       <= win_d;
      sticky_q    <= sticky_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_ch     = out_ch_q;
  assign out_data   = out_data_q;
  assign out_ovf    = out_ovf_q;
  assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_integrator_mc.sv
// Directed bench for integrator_mc: each task drives one scenario and checks hand-computed results.
module tb_integrator_mc;

  logic        clk, rst, enable, in_valid, in_ready;
  logic [1:0]  in_ch, mode, clear_ch, out_ch;
  logic [7:0]  in_data, dump_len;
  logic [3:0]  decay_shift, ovf_sticky;
  logic        sat_enable, clear, out_valid, out_ready, out_ovf;
  logic [15:0] sat_pos, sat_neg, out_data;

  int checks = 0;
  int failures = 0;

  integrator_mc dut (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_ready(in_ready),
    .in_ch(in_ch), .in_data(in_data), .mode(mode), .decay_shift(decay_shift),
    .dump_len(dump_len), .sat_enable(sat_enable), .sat_pos(sat_pos), .sat_neg(sat_neg),
    .clear(clear), .clear_ch(clear_ch), .out_valid(out_valid), .out_ready(out_ready),
    .out_ch(out_ch), .out_data(out_data), .out_ovf(out_ovf), .ovf_sticky(ovf_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send(input int ch, input int x);
    in_valid = 1'b1;
    in_ch    = ch[1:0];
    in_data  = x[7:0];
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic clr(input int ch);
    clear    = 1'b1;
    clear_ch = ch[1:0];
    @(posedge clk); #1;
    clear    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; enable = 1'b1; in_valid = 1'b0; in_ch = '0; in_data = '0;
    mode = 2'd0; decay_shift = '0; dump_len = 8'd1; sat_enable = 1'b0;
    sat_pos = 16'sd1000; sat_neg = -16'sd1000; clear = 1'b0; clear_ch = '0; out_ready = 1'b1;
    #2 rst = 1'b1;
    #10;
    checks++;
    if ({out_valid, out_ch, out_data, out_ovf, ovf_sticky} !== 24'd0) begin
      failures++;
      $display("FAIL reset_state got v=%b ch=%0d d=%0d o=%b s=%b exp all zero",
               out_valid, out_ch, out_data, out_ovf, ovf_sticky);
    end
    #1 rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle got rdy=%b v=%b exp rdy=1 v=0", in_ready, out_valid);
    end
  endtask

  task automatic test_accumulate();
    int xs [3] = '{10, 20, -5};
    int ex [3] = '{10, 30, 25};
    mode = 2'd0;
    for (int i = 0; i < 3; i++) begin
      send(0, xs[i]);
      checks++;
      if ({out_valid, out_ch} !== 3'b100 || out_data !== 16'(ex[i]) || out_ovf !== 1'b0) begin
        failures++;
        $display("FAIL acc_seq%0d got v=%b ch=%0d d=%0d o=%b exp v=1 ch=0 d=%0d o=0",
                 i, out_valid, out_ch, $signed(out_data), out_ovf, ex[i]);
      end
    end
  endtask

  task automatic test_leaky();
    clr(0);
    mode = 2'd0;
    send(0, 100);
    mode = 2'd1; decay_shift = 4'd2;
    send(0, 0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'd75) begin
      failures++;
      $display("FAIL leaky_k2 got v=%b d=%0d exp v=1 d=75", out_valid, $signed(out_data));
    end
    decay_shift = 4'd0;
    send(0, 7);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'd7) begin
      failures++;
      $display("FAIL leaky_k0 got v=%b d=%0d exp v=1 d=7", out_valid, $signed(out_data));
    end
    mode = 2'd0;
  endtask

  task automatic test_overflow();
    clr(0);
    sat_enable = 1'b1; sat_pos = 16'sd1000; sat_neg = -16'sd1000;
    for (int i = 0; i < 7; i++) send(0, 127);
    send(0, 101);
    checks++;
    if (out_data !== 16'd990 || out_ovf !== 1'b0 || ovf_sticky[0] !== 1'b0) begin
      failures++;
      $display("FAIL sat_pre got d=%0d o=%b s=%b exp d=990 o=0 s0=0",
               $signed(out_data), out_ovf, ovf_sticky);
    end
    send(0, 20);
    checks++;
    if (out_data !== 16'd1000 || out_ovf !== 1'b1 || ovf_sticky[0] !== 1'b1) begin
      failures++;
      $display("FAIL sat_clamp got d=%0d o=%b s=%b exp d=1000 o=1 s0=1",
               $signed(out_data), out_ovf, ovf_sticky);
    end
    sat_enable = 1'b0;
    for (int i = 0; i < 258; i++) send(3, 127);
    send(3, 1);
    checks++;
    if (out_data !== 16'h7fff || out_ovf !== 1'b0) begin
      failures++;
      $display("FAIL wrap_pre got d=%0d o=%b exp d=32767 o=0", $signed(out_data), out_ovf);
    end
    send(3, 1);
    checks++;
    if (out_data !== 16'h8000 || out_ovf !== 1'b1 || ovf_sticky !== 4'b1001) begin
      failures++;
      $display("FAIL wrap got d=%0d o=%b s=%b exp d=-32768 o=1 s=1001",
               $signed(out_data), out_ovf, ovf_sticky);
    end
  endtask

  task automatic test_dump();
    int xs [4] = '{1, 2, 3, 4};
    mode = 2'd2; dump_len = 8'd4;
    for (int i = 0; i < 3; i++) begin
      send(1, xs[i]);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL dump_quiet%0d got v=%b rdy=%b exp v=0 rdy=1", i, out_valid, in_ready);
      end
    end
    send(1, xs[3]);
    checks++;
    if ({out_valid, out_ch} !== 3'b101 || out_data !== 16'd10 || out_ovf !== 1'b0) begin
      failures++;
      $display("FAIL dump_emit got v=%b ch=%0d d=%0d o=%b exp v=1 ch=1 d=10 o=0",
               out_valid, out_ch, $signed(out_data), out_ovf);
    end
    send(1, 5); send(1, 0); send(1, 0); send(1, 0);
    checks++;
    if ({out_valid, out_ch} !== 3'b101 || out_data !== 16'd5) begin
      failures++;
      $display("FAIL dump_restart got v=%b ch=%0d d=%0d exp v=1 ch=1 d=5",
               out_valid, out_ch, $signed(out_data));
    end
    mode = 2'd0;
  endtask

  task automatic test_backpressure();
    clr(0); clr(2);
    send(0, 3);
    out_ready = 1'b0;
    in_valid = 1'b1; in_ch = 2'd2; in_data = 8'd4;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b0 || {out_valid, out_ch} !== 3'b100 || out_data !== 16'd3) begin
        failures++;
        $display("FAIL stall%0d got rdy=%b v=%b ch=%0d d=%0d exp rdy=0 v=1 ch=0 d=3",
                 i, in_ready, out_valid, out_ch, $signed(out_data));
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_ch} !== 3'b110 || out_data !== 16'd4) begin
      failures++;
      $display("FAIL stall_release got v=%b ch=%0d d=%0d exp v=1 ch=2 d=4",
               out_valid, out_ch, $signed(out_data));
    end
    send(0, 6);
    checks++;
    if ({out_valid, out_ch} !== 3'b100 || out_data !== 16'd9) begin
      failures++;
      $display("FAIL ileave_ch0 got v=%b ch=%0d d=%0d exp v=1 ch=0 d=9",
               out_valid, out_ch, $signed(out_data));
    end
    send(2, -1);
    checks++;
    if ({out_valid, out_ch} !== 3'b110 || out_data !== 16'd3) begin
      failures++;
      $display("FAIL ileave_ch2 got v=%b ch=%0d d=%0d exp v=1 ch=2 d=3",
               out_valid, out_ch, $signed(out_data));
    end
  endtask

  task automatic test_clear_enable_reset();
    clr(2);
    sat_enable = 1'b1; sat_pos = 16'sd50; sat_neg = -16'sd1000;
    send(2, 60);
    checks++;
    if (out_data !== 16'd50 || out_ovf !== 1'b1 || ovf_sticky[2] !== 1'b1) begin
      failures++;
      $display("FAIL clr_setup got d=%0d o=%b s=%b exp d=50 o=1 s2=1",
               $signed(out_data), out_ovf, ovf_sticky);
    end
    clear = 1'b1; clear_ch = 2'd2;
    send(2, 5);
    clear = 1'b0;
    checks++;
    if ({out_valid, out_ch} !== 3'b110 || out_data !== 16'd5 || out_ovf !== 1'b0 ||
        ovf_sticky !== 4'b1000) begin
      failures++;
      $display("FAIL clr_accept got v=%b ch=%0d d=%0d o=%b s=%b exp v=1 ch=2 d=5 o=0 s=1000",
               out_valid, out_ch, $signed(out_data), out_ovf, ovf_sticky);
    end
    enable = 1'b0;
    in_valid = 1'b1; in_ch = 2'd2; in_data = 8'd9;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL disable_rdy got rdy=%b exp 0", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL disable_drain got v=%b exp 0", out_valid);
    end
    enable = 1'b1;
    send(2, 1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'd6) begin
      failures++;
      $display("FAIL disable_hold got v=%b d=%0d exp v=1 d=6", out_valid, $signed(out_data));
    end
    out_ready = 1'b0;
    in_valid = 1'b1; in_ch = 2'd0; in_data = 8'd1;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_ch, out_data, out_ovf, ovf_sticky} !== 24'd0) begin
      failures++;
      $display("FAIL async_reset got v=%b ch=%0d d=%0d o=%b s=%b exp all zero",
               out_valid, out_ch, out_data, out_ovf, ovf_sticky);
    end
    in_valid = 1'b0;
    #3 rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_accumulate();
    test_leaky();
    test_overflow();
    test_dump();
    test_backpressure();
    test_clear_enable_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
